// File: rtl/uart_program_loader.sv
// UART program loader: receives an A5-headed word image over rx and writes it into the fetch
// instruction memory, holding the CPU in reset until done. Macro LOADER_CHECKSUM_EN adds an XOR check byte.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] HEADER = 8'hA5;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COUNT   = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd6;
    localparam logic [2:0] S_END     = S_CHECK;
`else
    localparam logic [2:0] S_END     = S_DONE;
`endif

    logic             rx_s1, rx_s2, rx_s3;
    logic [1:0]       r_state, r_state_nxt;
    logic [CNT_W-1:0] r_cnt, r_cnt_nxt;
    logic [2:0]       r_bit, r_bit_nxt;
    logic [7:0]       r_shift, r_shift_nxt;
    logic             byte_valid, byte_valid_nxt;
    logic             frame_err, frame_err_nxt;

    logic [2:0]        state, state_nxt;
    logic [7:0]        n_words, n_nxt;
    logic [7:0]        wcnt, wcnt_nxt, wcnt_inc;
    logic [ADDR_W-1:0] word_addr, addr_nxt;
    logic [7:0]        hi_byte, hi_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [15:0]       wdata_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk, chk_nxt;
`endif

    // rx synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge CLK) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= r_state_nxt;
            r_cnt      <= r_cnt_nxt;
            r_bit      <= r_bit_nxt;
            r_shift    <= r_shift_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // 8N1 receiver: start re-check at half bit, then data/stop sampled at each mid-bit
    always_comb begin
        r_state_nxt    = r_state;
        r_cnt_nxt      = r_cnt + CNT_W'(1);
        r_bit_nxt      = r_bit;
        r_shift_nxt    = r_shift;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (r_state)
            R_IDLE: begin
                r_cnt_nxt = '0;
                if (rx_s3 && !rx_s2) r_state_nxt = R_START;
            end
            R_START: begin
                if (r_cnt == HALF_END) begin
                    r_cnt_nxt   = '0;
                    r_bit_nxt   = '0;
                    r_state_nxt = rx_s2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_cnt == BIT_END) begin
                    r_cnt_nxt   = '0;
                    r_shift_nxt = {rx_s2, r_shift[7:1]};
                    r_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) r_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (r_cnt == BIT_END) begin
                    r_state_nxt    = R_IDLE;
                    byte_valid_nxt = rx_s2;
                    frame_err_nxt  = !rx_s2;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign wcnt_inc = wcnt + 8'd1;

    // loader sequencing on received bytes; a framing error wins from any state
    always_comb begin
        state_nxt = state;
        n_nxt     = n_words;
        wcnt_nxt  = wcnt;
        addr_nxt  = word_addr;
        hi_nxt    = hi_byte;
        we_nxt    = 1'b0;
        waddr_nxt = imem_addr;
        wdata_nxt = imem_wdata;
`ifdef LOADER_CHECKSUM_EN
        chk_nxt   = chk;
`endif
        if (frame_err) begin
            state_nxt = S_ERROR;
        end else if (byte_valid) begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (r_shift == HEADER) begin
                        state_nxt = S_COUNT;
`ifdef LOADER_CHECKSUM_EN
                        chk_nxt   = '0;
`endif
                    end
                end
                S_COUNT: begin
                    n_nxt     = r_shift;
                    wcnt_nxt  = '0;
                    addr_nxt  = '0;
                    state_nxt = (r_shift == 8'd0) ? S_END : S_DATA_HI;
                end
                S_DATA_HI: begin
                    hi_nxt    = r_shift;
                    state_nxt = S_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    chk_nxt   = chk ^ r_shift;
`endif
                end
                S_DATA_LO: begin
                    we_nxt    = 1'b1;
                    waddr_nxt = word_addr;
                    wdata_nxt = {hi_byte, r_shift};
                    addr_nxt  = word_addr + ADDR_W'(1);
                    wcnt_nxt  = wcnt_inc;
                    state_nxt = (wcnt_inc == n_words) ? S_END : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
                    chk_nxt   = chk ^ r_shift;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: state_nxt = (r_shift == chk) ? S_DONE : S_ERROR;
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= S_IDLE;
            n_words    <= '0;
            wcnt       <= '0;
            word_addr  <= '0;
            hi_byte    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            n_words    <= n_nxt;
            wcnt       <= wcnt_nxt;
            word_addr  <= addr_nxt;
            hi_byte    <= hi_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= waddr_nxt;
            imem_wdata <= wdata_nxt;
            cpu_rst    <= (state_nxt != S_DONE);
            load_done  <= (state_nxt == S_DONE);
            load_err   <= (state_nxt == S_ERROR);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (rst) chk <= '0;
        else     chk <= chk_nxt;
    end
`endif

endmodule
